event_encoder32: RTL and testbench

Sequential 32-to-5 event encoder: the inverse of the team's 5-to-32 one-hot decoder. Captures 32 single-cycle event lines into a pending register and emits them one at a time as 5-bit indices over a valid/ready handshake, using fixed or round-robin priority. It sits between event/interrupt sources and any consumer that works with a binary index, for example a register-file select or a dispatch table.

---
 rtl/event_encoder32.sv | 145 ++++++++++++++
 tb/tb_event_encoder32.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/event_encoder32.sv
// event_encoder32 -- sequential 32-to-5 event encoder.
// Captures single-cycle event pulses into a pending register and issues them
// one at a time as 5-bit indices over a valid/ready handshake, using fixed
// (lowest index first) or round-robin priority.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_in     in   [31:0] event pulses
//   clr_all    in   synchronous flush of pending and output register
//   ovf_clr    in   synchronous clear of overflow
//   out_ready  in   consumer accepts out_idx when high with out_valid
//   out_valid  out  out_idx holds a valid event
//   out_idx    out  [4:0] binary index of the issued event
//   out_onehot out  [31:0] 1 << out_idx while out_valid, else 0
//   pending    out  [31:0] captured events not yet loaded
//   overflow   out  sticky: event arrived for an already-pending bit
module event_encoder32 #(
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_in,
  input  logic        clr_all,
  input  logic        ovf_clr,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  out_idx,
  output logic [31:0] out_onehot,
  output logic [31:0] pending,
  output logic        overflow
);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pending;
  logic [31:0] r_onehot;
  logic [4:0]  r_idx;
  logic [4:0]  r_ptr;
  logic        r_ovf;

  logic [31:0] w_mask_hi;
  logic [4:0]  w_lo_all;
  logic [4:0]  w_lo_hi;
  logic        w_any;
  logic        w_hi_any;
  logic [4:0]  w_sel;
  logic        w_hs;
  logic        w_can_load;
  logic        w_do_load;
  logic [31:0] w_loaded;
  logic        w_ovf_set;

  // Round-robin: search bits at or above ptr first, fall back to lowest overall.
  assign w_mask_hi = r_pending & ({32{1'b1}} << r_ptr);

  always_comb begin
    w_lo_all = '0;
    w_any    = 1'b0;
    w_lo_hi  = '0;
    w_hi_any = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (!w_any && r_pending[i]) begin
        w_lo_all = 5'(i);
        w_any    = 1'b1;
      end
      if (!w_hi_any && w_mask_hi[i]) begin
        w_lo_hi  = 5'(i);
        w_hi_any = 1'b1;
      end
    end
  end

  assign w_sel      = ((ROUND_ROBIN != 0) && w_hi_any) ? w_lo_hi : w_lo_all;
  assign w_hs       = (r_state == HOLD) && out_ready;
  assign w_can_load = (r_state == EMPTY) || out_ready;
  assign w_do_load  = w_can_load && w_any;
  assign w_loaded   = w_do_load ? (32'd1 << w_sel) : '0;
  // A bit re-arriving in its own load cycle is a fresh capture, not an overflow.
  assign w_ovf_set  = |(req_in & r_pending & ~w_loaded);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (clr_all) begin
      w_state_next = EMPTY;
    end else if (w_can_load) begin
      w_state_next = w_any ? HOLD : EMPTY;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_onehot  <= '0;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      // A handshake coinciding with clr_all still counts as accepted.
      if (w_hs) begin
        r_ptr <= r_idx + 5'd1;
      end
      if (clr_all) begin
        r_pending <= '0;
        r_onehot  <= '0;
      end else begin
        r_pending <= (r_pending & ~w_loaded) | req_in;
        if (w_do_load) begin
          r_idx    <= w_sel;
          r_onehot <= w_loaded;
        end else if (w_can_load) begin
          r_onehot <= '0;
        end
      end
      if (w_ovf_set && !clr_all) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Outputs
  always_comb begin
    out_valid  = (r_state == HOLD);
    out_idx    = r_idx;
    out_onehot = r_onehot;
    pending    = r_pending;
    overflow   = r_ovf;
  end

endmodule

// File: tb/tb_event_encoder32.sv
// Testbench for event_encoder32: a round-robin instance (0) and a fixed
// priority instance (1) share stimulus. A behavioural model predicts each
// issued index into a queue; a monitor pops on every handshake and also
// compares state outputs every cycle.
module tb_event_encoder32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] req_in = '0;
  logic        clr_all = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        out_ready = 1'b0;

  logic        dv  [2];
  logic [4:0]  di  [2];
  logic [31:0] doh [2];
  logic [31:0] dp  [2];
  logic        dov [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  event_encoder32 #(.ROUND_ROBIN(1)) u_rr (
    .clk(clk), .rst(rst), .req_in(req_in), .clr_all(clr_all),
    .ovf_clr(ovf_clr), .out_ready(out_ready), .out_valid(dv[0]),
    .out_idx(di[0]), .out_onehot(doh[0]), .pending(dp[0]), .overflow(dov[0])
  );

  event_encoder32 #(.ROUND_ROBIN(0)) u_fix (
    .clk(clk), .rst(rst), .req_in(req_in), .clr_all(clr_all),
    .ovf_clr(ovf_clr), .out_ready(out_ready), .out_valid(dv[1]),
    .out_idx(di[1]), .out_onehot(doh[1]), .pending(dp[1]), .overflow(dov[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pend  [2];
  logic        m_valid [2];
  int          m_idx   [2];
  int          m_ptr   [2];
  logic        m_ovf   [2];
  int          q0[$];
  int          q1[$];

  bit          t_hs, t_can, t_found, t_newovf;
  int          t_s, t_j;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        m_pend[m] = '0; m_valid[m] = 1'b0; m_idx[m] = 0;
        m_ptr[m] = 0; m_ovf[m] = 1'b0;
      end
      q0.delete();
      q1.delete();
    end else begin
      for (int m = 0; m < 2; m++) begin
        t_hs    = m_valid[m] && out_ready;
        t_can   = !m_valid[m] || out_ready;
        t_found = 1'b0;
        t_s     = 0;
        if (t_can) begin
          for (int k = 0; k < 32; k++) begin
            t_j = (m == 0) ? (m_ptr[m] + k) % 32 : k;
            if (!t_found && m_pend[m][t_j]) begin
              t_found = 1'b1;
              t_s = t_j;
            end
          end
        end
        if (t_hs) m_ptr[m] = (m_idx[m] + 1) % 32;
        if (clr_all) begin
          if (m_valid[m] && !t_hs) begin
            if (m == 0) void'(q0.pop_back()); else void'(q1.pop_back());
          end
          m_pend[m]  = '0;
          m_valid[m] = 1'b0;
          if (ovf_clr) m_ovf[m] = 1'b0;
        end else begin
          t_newovf = 1'b0;
          for (int i = 0; i < 32; i++)
            if (req_in[i] && m_pend[m][i] && !(t_found && i == t_s)) t_newovf = 1'b1;
          if (t_newovf) m_ovf[m] = 1'b1;
          else if (ovf_clr) m_ovf[m] = 1'b0;
          if (t_found) m_pend[m][t_s] = 1'b0;
          m_pend[m] = m_pend[m] | req_in;
          if (t_found) begin
            m_valid[m] = 1'b1;
            m_idx[m]   = t_s;
            if (m == 0) q0.push_back(t_s); else q1.push_back(t_s);
          end else if (t_can) begin
            m_valid[m] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int exp_i;
  always @(negedge clk) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("valid%0d", m), 32'(dv[m]), 32'(m_valid[m]));
        chk($sformatf("pending%0d", m), dp[m], m_pend[m]);
        chk($sformatf("overflow%0d", m), 32'(dov[m]), 32'(m_ovf[m]));
        chk($sformatf("onehot%0d", m), doh[m], m_valid[m] ? (32'd1 << m_idx[m]) : 32'd0);
        if (dv[m] && out_ready) begin
          if ((m == 0 ? q0.size() : q1.size()) == 0) begin
            chk($sformatf("unexpected_issue%0d", m), 32'(di[m]), 32'hFFFF_FFFF);
          end else begin
            exp_i = (m == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("issue_idx%0d", m), 32'(di[m]), 32'(exp_i));
            chk($sformatf("issue_onehot%0d", m), doh[m], 32'd1 << exp_i);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [31:0] r, input logic rdy,
                      input logic c = 1'b0, input logic oc = 1'b0);
    req_in = r; out_ready = rdy; clr_all = c; ovf_clr = oc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check_async);
    req_in = '0; out_ready = 1'b0; clr_all = 1'b0; ovf_clr = 1'b0;
    #2 rst = 1'b1;
    #1;
    if (check_async) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("async_valid%0d", m), 32'(dv[m]), 32'd0);
        chk($sformatf("async_idx%0d", m), 32'(di[m]), 32'd0);
        chk($sformatf("async_onehot%0d", m), doh[m], 32'd0);
        chk($sformatf("async_pending%0d", m), dp[m], 32'd0);
        chk($sformatf("async_ovf%0d", m), 32'(dov[m]), 32'd0);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [31:0] rr;

  initial begin
    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst_valid%0d", m), 32'(dv[m]), 32'd0);
      chk($sformatf("rst_pending%0d", m), dp[m], 32'd0);
    end

    // single event
    step(32'h10, 1'b1);
    step(32'h0, 1'b1);
    chk("single_valid", 32'(dv[0]), 32'd1);
    chk("single_idx", 32'(di[0]), 32'd4);
    chk("single_onehot", doh[0], 32'h10);
    chk("single_pending", dp[0], 32'h0);
    step(32'h0, 1'b1);
    chk("single_drop", 32'(dv[0]), 32'd0);

    // round-robin order with wrap
    do_reset(1'b0);
    step(32'h8000_0003, 1'b1);
    step(32'h0, 1'b1); chk("rr_first", 32'(di[0]), 32'd0);
    step(32'h0, 1'b1); chk("rr_second", 32'(di[0]), 32'd1);
    step(32'h0, 1'b1); chk("rr_third", 32'(di[0]), 32'd31);
    step(32'h0, 1'b1); chk("rr_empty", 32'(dv[0]), 32'd0);
    step(32'h3, 1'b1);
    step(32'h0, 1'b1); chk("rr_wrap0", 32'(di[0]), 32'd0);
    step(32'h0, 1'b1); chk("rr_wrap1", 32'(di[0]), 32'd1);
    step(32'h0, 1'b1);

    // backpressure
    do_reset(1'b0);
    step(32'h300, 1'b0);
    for (int n = 0; n < 5; n++) begin
      step(32'h0, 1'b0);
      chk("bp_hold_idx", 32'(di[0]), 32'd8);
      chk("bp_hold_pend", dp[0], 32'h200);
    end
    step(32'h0, 1'b1); chk("bp_next", 32'(di[0]), 32'd9);
    step(32'h0, 1'b1); chk("bp_done", 32'(dv[0]), 32'd0);

    // overflow
    do_reset(1'b0);
    step(32'h100, 1'b0);
    step(32'h0, 1'b0);
    step(32'h200, 1'b0); chk("ovf_first", 32'(dov[0]), 32'd0);
    step(32'h200, 1'b0); chk("ovf_second", 32'(dov[0]), 32'd1);
    step(32'h100, 1'b0); chk("ovf_held_pend", dp[0], 32'h300);
    chk("ovf_held_flag", 32'(dov[0]), 32'd1);
    step(32'h0, 1'b0, 1'b0, 1'b1); chk("ovf_clr", 32'(dov[0]), 32'd0);
    for (int n = 0; n < 4; n++) step(32'h0, 1'b1);

    // fixed priority ordering
    do_reset(1'b0);
    step(32'h6, 1'b1);
    step(32'h1, 1'b1); chk("fix_a", 32'(di[1]), 32'd1);
    step(32'h0, 1'b1); chk("fix_b", 32'(di[1]), 32'd0);
    step(32'h0, 1'b1); chk("fix_c", 32'(di[1]), 32'd2);
    step(32'h0, 1'b1);

    // flush
    do_reset(1'b0);
    step(32'hFFFF_FFFF, 1'b0);
    step(32'h0, 1'b0);
    step(32'hFFFF_FFFF, 1'b0);
    chk("flush_pre_pend", dp[0], 32'hFFFF_FFFF);
    chk("flush_pre_valid", 32'(dv[0]), 32'd1);
    step(32'h1, 1'b0, 1'b1);
    chk("flush_pend", dp[0], 32'h0);
    chk("flush_valid", 32'(dv[0]), 32'd0);
    chk("flush_ovf_kept", 32'(dov[0]), 32'd1);

    // async reset mid-burst
    step(32'hF0F0, 1'b1);
    step(32'h0, 1'b1);
    step(32'h0, 1'b1);
    do_reset(1'b1);

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0:       rr = $urandom & $urandom;
        1:       rr = 32'd1 << $urandom_range(0, 31);
        2:       rr = $urandom;
        default: rr = '0;
      endcase
      step(rr, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0));
    end
    for (int n = 0; n < 40; n++) step(32'h0, 1'b1);
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
